// File: rtl/alpharetz_spi_pkg.sv
// Shared widths and sequencer state type for the Alpharetz SPI host bridge.
package alpharetz_spi_pkg;
  localparam int unsigned SPI_DATA_WIDTH = 8;
  localparam int unsigned P_ADDR_WIDTH   = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} bridge_state_t;
endpackage

// File: rtl/alpharetz_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; DEPTH must be a power of two >= 2.
module alpharetz_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/alpharetz_spi_host_bridge.sv
// CPU-to-SPI-controller bridge: command FIFO, sequencer, receive FIFO.
// Optional registered irq output with macro ALPHARETZ_SPI_BRIDGE_IRQ_EN.
module alpharetz_spi_host_bridge
  import alpharetz_spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          sys_clk_en,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [SPI_DATA_WIDTH-1:0]     cmd_data,
  input  logic [P_ADDR_WIDTH-1:0]       cmd_addr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [SPI_DATA_WIDTH-1:0]     rx_out,
  output logic                          spi_start,
  output logic [SPI_DATA_WIDTH-1:0]     spi_tx_data,
  output logic [P_ADDR_WIDTH-1:0]       spi_p_addr,
  input  logic                          spi_busy,
  input  logic                          spi_end,
  input  logic [SPI_DATA_WIDTH-1:0]     spi_rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_level,
  output logic                          rx_overflow,
  input  logic                          clr_overflow
`ifdef ALPHARETZ_SPI_BRIDGE_IRQ_EN
  ,
  output logic                          irq
`endif
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = P_ADDR_WIDTH + SPI_DATA_WIDTH;

  bridge_state_t             state;
  bridge_state_t             nxt;
  logic                      cmd_push;
  logic                      cmd_pop;
  logic                      cmd_full;
  logic                      cmd_empty;
  logic [CW-1:0]             cmd_head;
  logic                      rx_push;
  logic                      rx_pop;
  logic                      rx_full;
  logic                      rx_empty;
  logic [LW-1:0]             rx_level;
  logic                      capture;
  logic [SPI_DATA_WIDTH-1:0] rx_cap;

  assign cmd_ready = !cmd_full;
  assign rx_valid  = !rx_empty;
  assign cmd_push  = cmd_valid && !cmd_full && sys_clk_en;
  assign rx_pop    = rx_ready && !rx_empty && sys_clk_en;
  assign spi_start = (state == ISSUE);

  alpharetz_sync_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk(sys_clk), .rst_n(sys_rst_n), .push(cmd_push), .pop(cmd_pop),
    .wdata({cmd_addr, cmd_data}), .rdata(cmd_head),
    .full(cmd_full), .empty(cmd_empty), .level(cmd_level)
  );

  alpharetz_sync_fifo #(.WIDTH(SPI_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(sys_clk), .rst_n(sys_rst_n), .push(rx_push), .pop(rx_pop),
    .wdata(rx_cap), .rdata(rx_out),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  // Receive space is reserved when a command is issued, so STORE never sees a full FIFO.
  always_comb begin
    nxt     = state;
    cmd_pop = 1'b0;
    rx_push = 1'b0;
    capture = 1'b0;
    if (sys_clk_en) begin
      case (state)
        IDLE: if (!cmd_empty && !spi_busy && !rx_full) begin
          nxt     = ISSUE;
          cmd_pop = 1'b1;
        end
        ISSUE: if (spi_busy) nxt = WAIT;
        WAIT: if (spi_end) begin
          nxt     = STORE;
          capture = 1'b1;
        end
        STORE: begin
          rx_push = 1'b1;
          nxt     = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      spi_tx_data <= '0;
      spi_p_addr  <= '0;
      rx_cap      <= '0;
      rx_overflow <= 1'b0;
    end else if (sys_clk_en) begin
      state <= nxt;
      if (cmd_pop) {spi_p_addr, spi_tx_data} <= cmd_head;
      if (capture) rx_cap <= spi_rx_data;
      if (spi_end && state != WAIT) rx_overflow <= 1'b1;
      else if (clr_overflow)        rx_overflow <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rx_push) assert (rx_level != LW'(FIFO_DEPTH));
  end

`ifdef ALPHARETZ_SPI_BRIDGE_IRQ_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)      irq <= 1'b0;
    else if (sys_clk_en) irq <= rx_valid || rx_overflow;
  end
`endif
endmodule

// File: tb/tb_alpharetz_spi_host_bridge.sv
// Directed self-checking bench for alpharetz_spi_host_bridge (FIFO_DEPTH=4).
module tb_alpharetz_spi_host_bridge;
  import alpharetz_spi_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       sys_clk_en = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic [1:0] cmd_addr = '0;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_out;
  logic       spi_start;
  logic [7:0] spi_tx_data;
  logic [1:0] spi_p_addr;
  logic       spi_busy = 1'b0;
  logic       spi_end = 1'b0;
  logic [7:0] spi_rx_data = '0;
  logic [2:0] cmd_level;
  logic       rx_overflow;
  logic       clr_overflow = 1'b0;
`ifdef ALPHARETZ_SPI_BRIDGE_IRQ_EN
  logic       irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  alpharetz_spi_host_bridge #(.FIFO_DEPTH(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_clk_en(sys_clk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_addr(cmd_addr),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_out(rx_out),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_p_addr(spi_p_addr),
    .spi_busy(spi_busy), .spi_end(spi_end), .spi_rx_data(spi_rx_data),
    .cmd_level(cmd_level), .rx_overflow(rx_overflow), .clr_overflow(clr_overflow)
`ifdef ALPHARETZ_SPI_BRIDGE_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset;
    sys_rst_n = 1'b0;
    tick;
    sys_rst_n = 1'b1;
    tick;
  endtask

  // Starts in IDLE with a queued command and spi_busy low; ends one cycle after STORE.
  task automatic run_txn(input logic [7:0] rxd, input logic [7:0] etx, input logic [1:0] ea);
    tick;
    checks++;
    if (spi_start !== 1'b1 || spi_tx_data !== etx || spi_p_addr !== ea) begin
      errors++;
      $display("FAIL txn_issue: start=%b tx=%h addr=%0d, expected start=1 tx=%h addr=%0d",
               spi_start, spi_tx_data, spi_p_addr, etx, ea);
    end
    spi_busy = 1'b1;
    tick;
    spi_end = 1'b1;
    spi_rx_data = rxd;
    tick;
    spi_end = 1'b0;
    spi_busy = 1'b0;
    checks++;
    if (spi_tx_data !== etx || spi_p_addr !== ea || spi_start !== 1'b0) begin
      errors++;
      $display("FAIL txn_stable: tx=%h addr=%0d start=%b, expected tx=%h addr=%0d start=0",
               spi_tx_data, spi_p_addr, spi_start, etx, ea);
    end
    tick;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    checks++;
    if (spi_start !== 1'b0 || rx_valid !== 1'b0 || rx_overflow !== 1'b0 || cmd_ready !== 1'b1 ||
        cmd_level !== 3'd0 || spi_tx_data !== 8'h00 || spi_p_addr !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: start=%b rxv=%b ovf=%b rdy=%b lvl=%0d tx=%h addr=%0d, expected 0 0 0 1 0 00 0",
               spi_start, rx_valid, rx_overflow, cmd_ready, cmd_level, spi_tx_data, spi_p_addr);
    end
    sys_rst_n = 1'b1;
    tick;
  endtask

  task automatic test_latency;
    cmd_valid = 1'b1;
    cmd_data = 8'hA5;
    cmd_addr = 2'd2;
    tick;
    cmd_valid = 1'b0;
    checks++;
    if (spi_start !== 1'b0 || cmd_level !== 3'd1) begin
      errors++;
      $display("FAIL latency_cycle1: start=%b lvl=%0d, expected start=0 lvl=1", spi_start, cmd_level);
    end
    run_txn(8'h3C, 8'hA5, 2'd2);
    checks++;
    if (rx_valid !== 1'b1 || rx_out !== 8'h3C || rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rx_result: rxv=%b rx_out=%h ovf=%b, expected 1 3c 0", rx_valid, rx_out, rx_overflow);
    end
    rx_ready = 1'b1;
    tick;
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_pop: rxv=%b, expected 0", rx_valid);
    end
  endtask

  task automatic test_cmd_full_and_rx_full;
    int n;
    bit started;
    logic [7:0] exp_rx [4];
    spi_busy = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_data = 8'(16 + i);
      cmd_addr = 2'(i);
      tick;
    end
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || cmd_level !== 3'd4 || spi_start !== 1'b0) begin
      errors++;
      $display("FAIL cmd_full: rdy=%b lvl=%0d start=%b, expected 0 4 0", cmd_ready, cmd_level, spi_start);
    end
    spi_busy = 1'b0;
    for (int i = 0; i < 4; i++) run_txn(8'(8'hC0 + i), 8'(16 + i), 2'(i));
    checks++;
    if (rx_valid !== 1'b1 || rx_out !== 8'hC0 || cmd_level !== 3'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rx_filled: rxv=%b head=%h lvl=%0d rdy=%b, expected 1 c0 0 1",
               rx_valid, rx_out, cmd_level, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_data = 8'h77;
    cmd_addr = 2'd1;
    tick;
    cmd_valid = 1'b0;
    started = 1'b0;
    repeat (6) begin
      tick;
      if (spi_start === 1'b1) started = 1'b1;
    end
    checks++;
    if (started !== 1'b0 || cmd_level !== 3'd1) begin
      errors++;
      $display("FAIL rx_full_block: started=%b lvl=%0d, expected 0 1", started, cmd_level);
    end
    rx_ready = 1'b1;
    tick;
    rx_ready = 1'b0;
    n = 0;
    while (spi_start !== 1'b1 && n < 4) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 1 || spi_tx_data !== 8'h77 || spi_p_addr !== 2'd1) begin
      errors++;
      $display("FAIL rx_unblock: cycles=%0d tx=%h addr=%0d, expected 1 77 1", n, spi_tx_data, spi_p_addr);
    end
    spi_busy = 1'b1;
    tick;
    spi_end = 1'b1;
    spi_rx_data = 8'h5A;
    tick;
    spi_end = 1'b0;
    spi_busy = 1'b0;
    tick;
    exp_rx = '{8'hC1, 8'hC2, 8'hC3, 8'h5A};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_out !== exp_rx[i]) begin
        errors++;
        $display("FAIL rx_drain[%0d]: rxv=%b rx_out=%h, expected 1 %h", i, rx_valid, rx_out, exp_rx[i]);
      end
      rx_ready = 1'b1;
      tick;
      rx_ready = 1'b0;
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_empty: rxv=%b, expected 0", rx_valid);
    end
  endtask

  task automatic test_overflow;
    spi_end = 1'b1;
    tick;
    spi_end = 1'b0;
    checks++;
    if (rx_overflow !== 1'b1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_idle_end: ovf=%b rxv=%b, expected 1 0", rx_overflow, rx_valid);
    end
    clr_overflow = 1'b1;
    tick;
    clr_overflow = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear1: ovf=%b, expected 0", rx_overflow);
    end
    spi_end = 1'b1;
    clr_overflow = 1'b1;
    tick;
    spi_end = 1'b0;
    checks++;
    if (rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b, expected 1", rx_overflow);
    end
    tick;
    clr_overflow = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear2: ovf=%b, expected 0", rx_overflow);
    end
  endtask

  task automatic test_clk_en;
    sys_clk_en = 1'b0;
    cmd_valid = 1'b1;
    cmd_data = 8'h99;
    cmd_addr = 2'd3;
    repeat (3) tick;
    checks++;
    if (cmd_level !== 3'd0) begin
      errors++;
      $display("FAIL clken_no_push: lvl=%0d, expected 0", cmd_level);
    end
    sys_clk_en = 1'b1;
    tick;
    cmd_valid = 1'b0;
    sys_clk_en = 1'b0;
    repeat (3) tick;
    checks++;
    if (cmd_level !== 3'd1 || spi_start !== 1'b0) begin
      errors++;
      $display("FAIL clken_hold: lvl=%0d start=%b, expected 1 0", cmd_level, spi_start);
    end
    sys_clk_en = 1'b1;
    tick;
    checks++;
    if (spi_start !== 1'b1 || spi_tx_data !== 8'h99 || spi_p_addr !== 2'd3) begin
      errors++;
      $display("FAIL clken_issue: start=%b tx=%h addr=%0d, expected 1 99 3", spi_start, spi_tx_data, spi_p_addr);
    end
    sys_clk_en = 1'b0;
    spi_end = 1'b1;
    tick;
    spi_end = 1'b0;
    sys_clk_en = 1'b1;
    checks++;
    if (rx_overflow !== 1'b0 || spi_start !== 1'b1) begin
      errors++;
      $display("FAIL clken_end_ignored: ovf=%b start=%b, expected 0 1", rx_overflow, spi_start);
    end
  endtask

  task automatic test_reset_in_wait;
    do_reset;
    cmd_valid = 1'b1;
    cmd_data = 8'h21;
    cmd_addr = 2'd0;
    tick;
    cmd_data = 8'h22;
    tick;
    cmd_valid = 1'b0;
    spi_busy = 1'b1;
    tick;
    checks++;
    if (spi_start !== 1'b0 || cmd_level !== 3'd1 || spi_tx_data !== 8'h21) begin
      errors++;
      $display("FAIL wait_entry: start=%b lvl=%0d tx=%h, expected 0 1 21", spi_start, cmd_level, spi_tx_data);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_level !== 3'd0 || rx_valid !== 1'b0 || spi_start !== 1'b0 || spi_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_in_wait: lvl=%0d rxv=%b start=%b tx=%h, expected 0 0 0 00",
               cmd_level, rx_valid, spi_start, spi_tx_data);
    end
    tick;
    sys_rst_n = 1'b1;
    spi_end = 1'b1;
    spi_rx_data = 8'hEE;
    tick;
    spi_end = 1'b0;
    spi_busy = 1'b0;
    tick;
    checks++;
    if (rx_overflow !== 1'b1 || rx_valid !== 1'b0 || spi_start !== 1'b0) begin
      errors++;
      $display("FAIL late_end_discard: ovf=%b rxv=%b start=%b, expected 1 0 0", rx_overflow, rx_valid, spi_start);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_cmd_full_and_rx_full;
    test_overflow;
    test_clk_en;
    test_reset_in_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, expected completion");
    $fatal(1, "timeout");
  end
endmodule
